// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store initiator. Turns EX/MEM MemRead/MemWrite requests into
// handshaked data-memory transactions (big-endian byte lanes), stalls the
// pipeline while a transaction is in flight and returns extended load data.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_ex_mm,
  input  logic        MemWrite_ex_mm,
  input  logic [1:0]  size_ex_mm,
  input  logic        sign_ext_ex_mm,
  input  logic [31:0] address,
  input  logic [31:0] foutput2_ex_mm,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

  state_e      state_q, state_d;
  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q, off_q;
  logic [7:0]  cnt_q, cnt_inc;
  logic [31:0] dm_addr_q, dm_wdata_q, load_data_q;
  logic [3:0]  dm_be_q;

  logic        req_any, aligned, start, timeout, tmo_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, rdata_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign req_any = MemRead_ex_mm | MemWrite_ex_mm;
  assign start   = (state_q == IDLE) && req_any && aligned;
  assign cnt_inc = cnt_q + 8'd1;
  assign timeout = (cnt_inc == TIMEOUT_LIM);

  // Alignment check, byte enables and lane-replicated store data for a new request.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = foutput2_ex_mm;
    unique case (size_ex_mm)
      2'b00: begin
        be_d    = 4'b1000 >> address[1:0];
        wdata_d = {4{foutput2_ex_mm[7:0]}};
      end
      2'b01: begin
        aligned = ~address[0];
        be_d    = address[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{foutput2_ex_mm[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Big-endian lane extraction and sign/zero extension of returned read data.
  always_comb begin
    unique case (off_q)
      2'd0: byte_sel = dm_rdata[31:24];
      2'd1: byte_sel = dm_rdata[23:16];
      2'd2: byte_sel = dm_rdata[15:8];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = off_q[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    unique case (size_q)
      2'b00:   rdata_ext = sign_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      2'b01:   rdata_ext = sign_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      default: rdata_ext = dm_rdata;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a completed handshake wins over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = REQ;
      REQ: begin
        if (dm_gnt)       state_d = we_q ? DONE : WAIT_R;
        else if (timeout) begin state_d = DONE; tmo_hit = 1'b1; end
      end
      WAIT_R: begin
        if (dm_rvalid)    state_d = DONE;
        else if (timeout) begin state_d = DONE; tmo_hit = 1'b1; end
      end
      DONE:   state_d = IDLE;
    endcase
  end

  // Output decode; IDLE outputs depend on live request inputs and are held low in reset.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    dm_req     = 1'b0;
    load_valid = 1'b0;
    bus_error  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall      = start;
        misaligned = req_any && !aligned;
      end
      REQ: begin
        dm_req = 1'b1;
        stall  = 1'b1;
      end
      WAIT_R: stall = 1'b1;
      DONE: begin
        load_valid = ~we_q;
        bus_error  = err_q;
      end
    endcase
    if (reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  // Transaction latch, timeout counter and registered load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      dm_addr_q   <= 32'h0;
      dm_be_q     <= 4'h0;
      dm_wdata_q  <= 32'h0;
      cnt_q       <= 8'h0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      err_q <= tmo_hit;
      if (start) begin
        we_q       <= MemWrite_ex_mm;
        sign_q     <= sign_ext_ex_mm;
        size_q     <= size_ex_mm;
        off_q      <= address[1:0];
        dm_addr_q  <= {address[31:2], 2'b00};
        dm_be_q    <= be_d;
        dm_wdata_q <= wdata_d;
        cnt_q      <= 8'h0;
      end else if (state_q == REQ || state_q == WAIT_R) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == WAIT_R && dm_rvalid) load_data_q <= rdata_ext;
      else if (tmo_hit && !we_q)          load_data_q <= 32'h0;
    end
  end

  assign dm_we     = we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_be     = dm_be_q;
  assign dm_wdata  = dm_wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: word/byte/half loads, stores, misalignment,
// timeout and asynchronous reset in the middle of a transaction.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead_ex_mm, MemWrite_ex_mm, sign_ext_ex_mm;
  logic [1:0]  size_ex_mm;
  logic [31:0] address, foutput2_ex_mm;
  logic        stall, load_valid, misaligned, bus_error;
  logic [31:0] load_data;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .MemRead_ex_mm(MemRead_ex_mm), .MemWrite_ex_mm(MemWrite_ex_mm),
    .size_ex_mm(size_ex_mm), .sign_ext_ex_mm(sign_ext_ex_mm),
    .address(address), .foutput2_ex_mm(foutput2_ex_mm),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_error(bus_error),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load with gnt on the first REQ cycle and rvalid on the next cycle.
  task automatic bus_read(input logic [31:0] addr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] rd, output logic [31:0] got_addr,
                          output logic [3:0] got_be, output logic [31:0] got_data,
                          output logic got_valid);
    MemRead_ex_mm = 1'b1; address = addr; size_ex_mm = sz; sign_ext_ex_mm = sx;
    tick();
    MemRead_ex_mm = 1'b0;
    got_addr = dm_addr; got_be = dm_be; dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = rd;
    tick();
    dm_rvalid = 1'b0;
    #1;
    got_data = load_data; got_valid = load_valid;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ga, gd;
    logic [3:0]  gb;
    logic        gv;
    int          n, stall_cnt;
    logic        early_err;

    reset = 1'b1;
    MemRead_ex_mm = 0; MemWrite_ex_mm = 0; sign_ext_ex_mm = 0; size_ex_mm = 2'b00;
    address = 32'h0; foutput2_ex_mm = 32'h0; dm_gnt = 0; dm_rvalid = 0; dm_rdata = 32'h0;
    repeat (3) tick();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dm_req), 32'd0);
    check("rst_ld", load_data, 32'h0);
    check("rst_lv", 32'(load_valid), 32'd0);
    reset = 1'b0;
    tick();

    // 1. Word load, gnt on first REQ cycle, rvalid two cycles later.
    stall_cnt = 0;
    MemRead_ex_mm = 1; address = 32'h0000000C; size_ex_mm = 2'b10;
    #1; if (stall) stall_cnt++;
    check("w_idle_req", 32'(dm_req), 32'd0);
    tick();
    MemRead_ex_mm = 0; dm_gnt = 1;
    #1; if (stall) stall_cnt++;
    check("w_req", 32'(dm_req), 32'd1);
    check("w_addr", dm_addr, 32'h0000000C);
    check("w_be", 32'(dm_be), 32'hF);
    check("w_we", 32'(dm_we), 32'd0);
    tick();
    dm_gnt = 0;
    #1; if (stall) stall_cnt++;
    check("w_wait_req", 32'(dm_req), 32'd0);
    tick();
    dm_rvalid = 1; dm_rdata = 32'h12345678;
    #1; if (stall) stall_cnt++;
    tick();
    dm_rvalid = 0;
    #1; if (stall) stall_cnt++;
    check("w_stall_cycles", 32'(stall_cnt), 32'd4);
    check("w_lv", 32'(load_valid), 32'd1);
    check("w_ld", load_data, 32'h12345678);
    tick();
    check("w_lv_pulse", 32'(load_valid), 32'd0);
    check("w_ld_hold", load_data, 32'h12345678);

    // 2. Byte loads at offset 1, signed and unsigned; half load at offset 2.
    bus_read(32'h00000009, 2'b00, 1'b1, 32'h0080FF00, ga, gb, gd, gv);
    check("bs_addr", ga, 32'h00000008);
    check("bs_be", 32'(gb), 32'h4);
    check("bs_data", gd, 32'hFFFFFF80);
    check("bs_lv", 32'(gv), 32'd1);
    bus_read(32'h00000009, 2'b00, 1'b0, 32'h0080FF00, ga, gb, gd, gv);
    check("bu_addr", ga, 32'h00000008);
    check("bu_data", gd, 32'h00000080);
    bus_read(32'h00000002, 2'b01, 1'b1, 32'h0080FF00, ga, gb, gd, gv);
    check("hs_be", 32'(gb), 32'h3);
    check("hs_data", gd, 32'hFFFFFF00);
    bus_read(32'h00000000, 2'b01, 1'b0, 32'h8001FF00, ga, gb, gd, gv);
    check("hu_data", gd, 32'h00008001);

    // 3. Half store at 0x6 with gnt delayed 3 cycles; inputs change while stalled.
    MemWrite_ex_mm = 1; address = 32'h00000006; size_ex_mm = 2'b01; foutput2_ex_mm = 32'h0000ABCD;
    #1;
    check("hw_idle_stall", 32'(stall), 32'd1);
    tick();
    MemWrite_ex_mm = 0; address = 32'hFFFFFFFF; foutput2_ex_mm = 32'h11112222;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hw_req", 32'(dm_req), 32'd1);
      check("hw_we", 32'(dm_we), 32'd1);
      check("hw_be", 32'(dm_be), 32'h3);
      check("hw_wdata", dm_wdata, 32'hABCDABCD);
      check("hw_addr", dm_addr, 32'h00000004);
      tick();
    end
    dm_gnt = 1;
    #1;
    check("hw_req_gnt", 32'(dm_req), 32'd1);
    tick();
    dm_gnt = 0;
    #1;
    check("hw_done_stall", 32'(stall), 32'd0);
    check("hw_done_lv", 32'(load_valid), 32'd0);
    check("hw_done_req", 32'(dm_req), 32'd0);
    tick();

    // Byte store at offset 3.
    MemWrite_ex_mm = 1; address = 32'h00000003; size_ex_mm = 2'b00; foutput2_ex_mm = 32'h1234565A;
    tick();
    MemWrite_ex_mm = 0; dm_gnt = 1;
    #1;
    check("bw_be", 32'(dm_be), 32'h1);
    check("bw_wdata", dm_wdata, 32'h5A5A5A5A);
    check("bw_addr", dm_addr, 32'h00000000);
    tick();
    dm_gnt = 0;
    tick();

    // 4. Misaligned word read.
    MemRead_ex_mm = 1; address = 32'h00000002; size_ex_mm = 2'b10;
    #1;
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_stall", 32'(stall), 32'd0);
    check("mis_req", 32'(dm_req), 32'd0);
    tick();
    MemRead_ex_mm = 0;
    #1;
    check("mis_clear", 32'(misaligned), 32'd0);
    check("mis_req2", 32'(dm_req), 32'd0);
    tick();

    // 5. Timeout with dm_gnt held low.
    MemRead_ex_mm = 1; address = 32'h00000010; size_ex_mm = 2'b10;
    tick();
    MemRead_ex_mm = 0;
    n = 0; early_err = 1'b0;
    while (dm_req === 1'b1 && n < 40) begin
      if (bus_error) early_err = 1'b1;
      n++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_no_early_err", 32'(early_err), 32'd0);
    check("to_err", 32'(bus_error), 32'd1);
    check("to_lv", 32'(load_valid), 32'd1);
    check("to_ld", load_data, 32'h0);
    check("to_stall", 32'(stall), 32'd0);
    dm_rvalid = 1; dm_rdata = 32'hDEADBEEF;
    tick();
    check("to_err_pulse", 32'(bus_error), 32'd0);
    check("to_late_lv", 32'(load_valid), 32'd0);
    tick();
    dm_rvalid = 0;
    check("to_late_ld", load_data, 32'h0);

    // 6a. Reset asserted asynchronously in REQ.
    MemRead_ex_mm = 1; address = 32'h00000020; size_ex_mm = 2'b10;
    tick();
    MemRead_ex_mm = 0;
    #1;
    check("rq_pre_req", 32'(dm_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rq_req", 32'(dm_req), 32'd0);
    check("rq_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 6b. Reset asserted asynchronously in WAIT_R, then a stray rvalid.
    bus_read(32'h00000004, 2'b10, 1'b0, 32'hCAFEF00D, ga, gb, gd, gv);
    check("rw_setup_ld", gd, 32'hCAFEF00D);
    MemRead_ex_mm = 1; address = 32'h00000020; size_ex_mm = 2'b10;
    tick();
    MemRead_ex_mm = 0; dm_gnt = 1;
    tick();
    dm_gnt = 0;
    #1;
    check("rw_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("rw_req", 32'(dm_req), 32'd0);
    check("rw_stall", 32'(stall), 32'd0);
    check("rw_lv", 32'(load_valid), 32'd0);
    check("rw_ld", load_data, 32'h0);
    tick();
    reset = 1'b0;
    dm_rvalid = 1; dm_rdata = 32'h55555555;
    tick();
    check("rw_stray_lv", 32'(load_valid), 32'd0);
    check("rw_stray_stall", 32'(stall), 32'd0);
    tick();
    dm_rvalid = 0;
    check("rw_stray_lv2", 32'(load_valid), 32'd0);
    check("rw_stray_ld", load_data, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
